// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, ASCII constants and character classes.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EQ  = 3'd4;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_SLASH = 8'h2F;
  localparam logic [7:0] ASC_EQUAL = 8'h3D;

  typedef enum logic [2:0] {
    DIGIT,
    OPER,
    TERM,
    BS,
    BAD
  } char_class_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACCUM,
    ST_HOLD
  } parser_state_e;

endpackage

// File: rtl/ascii_classifier.sv
// Combinational decode of one ASCII character into class, digit value and operator code.
module ascii_classifier
  import calc_pkg::*;
(
  input  logic [7:0]  in_ascii,
  output char_class_e cls_c,
  output logic [3:0]  digit_c,
  output logic [2:0]  op_c
);

  always_comb begin
    cls_c   = BAD;
    digit_c = 4'd0;
    op_c    = OP_EQ;
    if (in_ascii >= ASC_0 && in_ascii <= ASC_9) begin
      cls_c   = DIGIT;
      digit_c = 4'(in_ascii - ASC_0);
    end else begin
      case (in_ascii)
        ASC_PLUS:  begin cls_c = OPER; op_c = OP_ADD; end
        ASC_MINUS: begin cls_c = OPER; op_c = OP_SUB; end
        ASC_STAR:  begin cls_c = OPER; op_c = OP_MUL; end
        ASC_SLASH: begin cls_c = OPER; op_c = OP_DIV; end
        ASC_EQUAL,
        ASC_CR:    begin cls_c = TERM; op_c = OP_EQ;  end
        ASC_BS:    cls_c = BS;
        default:   cls_c = BAD;
      endcase
    end
  end

endmodule

// File: rtl/operand_parser.sv
// Accumulates multi-digit decimal operands from an ASCII stream and emits operand/operator tokens.
// Optional backspace editing is enabled by defining OPERAND_PARSER_BACKSPACE_EN.
module operand_parser
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned NUM_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_ascii,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_number,
  output logic [2:0]       out_op,
  output logic             out_ovf,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned ACC_W = NUM_W + 4;

  parser_state_e    state_q, state_d;
  logic [NUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [NUM_W-1:0] out_number_q, out_number_d;
  logic [2:0]       out_op_q, out_op_d;
  logic             out_ovf_q, out_ovf_d;
  logic             err_q, err_d;

  char_class_e      cls_c;
  logic [3:0]       digit_c;
  logic [2:0]       op_c;
  logic             accept_c;
  logic [ACC_W-1:0] acc_ext_c;

  ascii_classifier u_classifier (
    .in_ascii (in_ascii),
    .cls_c    (cls_c),
    .digit_c  (digit_c),
    .op_c     (op_c)
  );

  assign in_ready  = !out_valid_q;
  assign accept_c  = in_valid && !out_valid_q;
  assign acc_ext_c = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit_c);

`ifdef OPERAND_PARSER_BACKSPACE_EN
  logic [NUM_W-1:0] acc_div10_c;
  assign acc_div10_c = acc_q / NUM_W'(10);
`endif

  // Next-state, accumulator and token register logic
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    out_number_d = out_number_q;
    out_op_d     = out_op_q;
    out_ovf_d    = out_ovf_q;
    err_d        = 1'b0;

    case (state_q)
      ST_EMPTY, ST_ACCUM: begin
        if (accept_c) begin
          case (cls_c)
            DIGIT: begin
              // Digits past the limit are silently dropped but remembered via ovf
              if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                acc_d   = NUM_W'(acc_ext_c);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_ACCUM;
              end else begin
                ovf_d = 1'b1;
              end
            end
            OPER, TERM: begin
              if (state_q == ST_ACCUM) begin
                out_number_d = acc_q;
                out_op_d     = op_c;
                out_ovf_d    = ovf_q;
                out_valid_d  = 1'b1;
                state_d      = ST_HOLD;
              end else begin
                err_d = 1'b1;
              end
            end
`ifdef OPERAND_PARSER_BACKSPACE_EN
            BS: begin
              if (state_q == ST_ACCUM) begin
                acc_d = acc_div10_c;
                cnt_d = cnt_q - CNT_W'(1);
                ovf_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_EMPTY;
                end
              end else begin
                err_d = 1'b1;
              end
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_number_q <= '0;
      out_op_q     <= OP_ADD;
      out_ovf_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_number_q <= out_number_d;
      out_op_q     <= out_op_d;
      out_ovf_q    <= out_ovf_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_number = out_number_q;
  assign out_op     = out_op_q;
  assign out_ovf    = out_ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_operand_parser.sv
// Scoreboard bench for operand_parser: directed character streams, tokens checked by a monitor.
module tb_operand_parser;

  localparam int unsigned NUM_W = 10;

  typedef struct {
    int unsigned num;
    int unsigned op;
    int unsigned ovf;
  } tok_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_ascii;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] out_number;
  logic [2:0]       out_op;
  logic             out_ovf;
  logic             err;

  tok_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   valid_cycles = 0;
  int   tok_cnt = 0;

  operand_parser #(.MAX_DIGITS(3), .NUM_W(NUM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ascii   (in_ascii),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_number (out_number),
    .out_op     (out_op),
    .out_ovf    (out_ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: compare every presented token against the scoreboard head, pop on handshake
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (rst_n && out_valid === 1'b1) begin
      valid_cycles++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_token actual number=%0d op=%0d required none", out_number, out_op);
      end else begin
        chk("tok_number", 32'(out_number), sb[0].num);
        chk("tok_op", 32'(out_op), sb[0].op);
        chk("tok_ovf", 32'(out_ovf), sb[0].ovf);
        if (out_ready) begin
          void'(sb.pop_front());
          tok_cnt++;
        end
      end
    end
  end

  task automatic push(input int unsigned num, input int unsigned op, input int unsigned ovf);
    tok_t t;
    t.num = num; t.op = op; t.ovf = ovf;
    sb.push_back(t);
  endtask

  // Present one character and hold it until accepted (bounded)
  task automatic send(input logic [7:0] c);
    int n = 0;
    bit taken = 1'b0;
    in_valid = 1'b1;
    in_ascii = c;
    do begin
      taken = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!taken && n < 50);
    if (!taken) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int e0, v0, t0;
    in_valid  = 1'b0;
    in_ascii  = 8'h00;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_number", 32'(out_number), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 123+ back-to-back, single-cycle token
    e0 = err_seen; v0 = valid_cycles;
    push(123, 0, 0);
    send("1"); send("2"); send("3"); send("+");
    drain();
    chk("t1_valid_cycles", valid_cycles - v0, 1);
    chk("t1_err", err_seen - e0, 0);

    // fourth digit dropped, overflow flagged without err
    e0 = err_seen;
    push(456, 4, 1);
    send("4"); send("5"); send("6"); send("7"); send("=");
    drain();
    chk("t2_err", err_seen - e0, 0);

    // bad char and operator from EMPTY, then 9 CR
    e0 = err_seen;
    send("x"); send("*");
    @(posedge clk); #1;
    chk("t3_no_token", 32'(out_valid), 0);
    push(9, 4, 0);
    send("9"); send(8'h0D);
    drain();
    chk("t3_err", err_seen - e0, 2);

    // consumer stall for 5 cycles
    t0 = tok_cnt;
    out_ready = 1'b0;
    push(8, 3, 0);
    send("8"); send("/");
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 32'(out_valid), 1);
      chk("t4_stall_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    chk("t4_consumed_once", tok_cnt - t0, 1);

    // reset mid-operand discards 72
    send("7"); send("2");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(5, 1, 0);
    send("5"); send("-");
    drain();

    // boundaries: full-width operand and leading zeros
    push(999, 4, 0);
    send("9"); send("9"); send("9"); send(8'h0D);
    push(7, 2, 0);
    send("0"); send("0"); send("7"); send("*");
    drain();

    // backspace in EMPTY is always an error
    e0 = err_seen;
    send(8'h08);
    @(posedge clk); #1;
    chk("bs_empty_err", err_seen - e0, 1);

`ifdef OPERAND_PARSER_BACKSPACE_EN
    e0 = err_seen;
    push(13, 0, 0);
    send("1"); send("2"); send(8'h08); send("3"); send("+");
    drain();
    chk("bs_edit_err", err_seen - e0, 0);
`else
    e0 = err_seen;
    push(12, 0, 0);
    send("1"); send(8'h08); send("2"); send("+");
    drain();
    chk("bs_invalid_err", err_seen - e0, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
